// File: rtl/writeback_pkg.sv
// Shared pipeline definitions used by the writeback stage: result-select
// encodings, the writeback FSM state encoding and exception cause codes.
package writeback_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned CSR_AW     = 12;
  localparam int unsigned CAUSE_W    = 4;
  localparam int unsigned INSTRET_W  = 64;

  // Which candidate result is written to the register file.
  typedef enum logic [1:0] {
    WB_SEL_ALU     = 2'b00,
    WB_SEL_CSR     = 2'b01,
    WB_SEL_LOAD    = 2'b10,
    WB_SEL_NEXT_PC = 2'b11
  } wb_sel_e;

  // Writeback FSM: normal retirement, or asleep after a WFI.
  typedef enum logic {
    WB_ST_RUN   = 1'b0,
    WB_ST_SLEEP = 1'b1
  } wb_state_e;

  // Synchronous exception causes reported on trap_cause.
  localparam logic [CAUSE_W-1:0] ECAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [CAUSE_W-1:0] ECAUSE_INSTR_FAULT      = 4'd1;
  localparam logic [CAUSE_W-1:0] ECAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [CAUSE_W-1:0] ECAUSE_BREAKPOINT       = 4'd3;
  localparam logic [CAUSE_W-1:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [CAUSE_W-1:0] ECAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [CAUSE_W-1:0] ECAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [CAUSE_W-1:0] ECAUSE_STORE_FAULT      = 4'd7;
  localparam logic [CAUSE_W-1:0] ECAUSE_ECALL_M          = 4'd11;

  // Pick the register-file write value for a given select code.
  function automatic logic [XLEN-1:0] select_result(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] alu_data,
    input logic [XLEN-1:0] csr_data,
    input logic [XLEN-1:0] load_data,
    input logic [XLEN-1:0] next_pc
  );
    logic [XLEN-1:0] result;
    case (wb_sel_e'(sel))
      WB_SEL_ALU:     result = alu_data;
      WB_SEL_CSR:     result = csr_data;
      WB_SEL_LOAD:    result = load_data;
      WB_SEL_NEXT_PC: result = next_pc;
      default:        result = alu_data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/writeback_retire_counter.sv
// Free-running retired-instruction counter: counts enabled cycles and wraps
// from all-ones back to zero.
module retire_counter
  import writeback_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic [INSTRET_W-1:0] count
);

  // Count register: clear on reset, otherwise advance on each enabled cycle.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= count + INSTRET_W'(1);
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: selects the register-file result, issues CSR writes,
// raises traps and mret strobes, counts retirements and sleeps on WFI until
// an enabled interrupt is pending.
module writeback
  import writeback_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [XLEN-1:0]      next_pc_in,
  input  logic [XLEN-1:0]      alu_data_in,
  input  logic [XLEN-1:0]      csr_data_in,
  input  logic [XLEN-1:0]      load_data_in,
  input  logic [1:0]           write_select_in,
  input  logic [REG_AW-1:0]    rd_address_in,
  input  logic [CSR_AW-1:0]    csr_address_in,
  input  logic                 csr_write_in,
  input  logic                 mret_in,
  input  logic                 wfi_in,
  input  logic                 valid_in,
  input  logic                 exception_in,
  input  logic [CAUSE_W-1:0]   ecause_in,
  input  logic                 interrupt_pending,
  output logic [REG_AW-1:0]    rd_write_address,
  output logic [XLEN-1:0]      rd_write_data,
  output logic                 csr_write_enable,
  output logic [CSR_AW-1:0]    csr_write_address,
  output logic [XLEN-1:0]      csr_write_data,
  output logic                 trap,
  output logic                 mret_taken,
  output logic [CAUSE_W-1:0]   trap_cause,
  output logic [XLEN-1:0]      trap_pc,
  output logic                 wfi_stall,
  output logic                 retired,
  output logic [INSTRET_W-1:0] instret
);

  wb_state_e state;
  wb_state_e state_next;
  logic      running;
  logic      commit;
  logic      trap_now;

  // Slot qualification: only a valid slot in RUN can commit or trap, and an
  // exception always wins over a normal commit.
  always_comb begin
    running  = (state == WB_ST_RUN);
    commit   = valid_in && !exception_in && running;
    trap_now = valid_in &&  exception_in && running;
  end

  // State register; reset forces RUN over any concurrent WFI or wake-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WB_ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: sleep on a committed WFI with nothing pending, wake on
  // the first cycle an enabled interrupt is seen.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      WB_ST_RUN: begin
        if (commit && wfi_in && !interrupt_pending) begin
          state_next = WB_ST_SLEEP;
        end
      end
      WB_ST_SLEEP: begin
        if (interrupt_pending) begin
          state_next = WB_ST_RUN;
        end
      end
      default: state_next = WB_ST_RUN;
    endcase
  end

  // Register-file and CSR write port; address 0 means no register write.
  always_comb begin
    rd_write_data     = select_result(write_select_in, alu_data_in, csr_data_in,
                                      load_data_in, next_pc_in);
    rd_write_address  = commit ? rd_address_in : '0;
    csr_write_enable  = commit && csr_write_in;
    csr_write_address = csr_address_in;
    csr_write_data    = alu_data_in;
  end

  // Control strobes toward the CSR unit, fetch and hazard logic.
  always_comb begin
    trap       = trap_now;
    trap_cause = ecause_in;
    trap_pc    = pc_in;
    mret_taken = commit && mret_in;
    retired    = commit;
    wfi_stall  = (state == WB_ST_SLEEP);
  end

  retire_counter u_retire_counter (
    .clk    (clk),
    .reset  (reset),
    .enable (commit),
    .count  (instret)
  );

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for the writeback stage.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in;
  logic [1:0]  write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic        csr_write_in, mret_in, wfi_in, valid_in, exception_in;
  logic [3:0]  ecause_in;
  logic        interrupt_pending;
  logic [4:0]  rd_write_address;
  logic [31:0] rd_write_data;
  logic        csr_write_enable;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic        trap, mret_taken;
  logic [3:0]  trap_cause;
  logic [31:0] trap_pc;
  logic        wfi_stall, retired;
  logic [63:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback dut (
    .clk               (clk),
    .reset             (reset),
    .pc_in             (pc_in),
    .next_pc_in        (next_pc_in),
    .alu_data_in       (alu_data_in),
    .csr_data_in       (csr_data_in),
    .load_data_in      (load_data_in),
    .write_select_in   (write_select_in),
    .rd_address_in     (rd_address_in),
    .csr_address_in    (csr_address_in),
    .csr_write_in      (csr_write_in),
    .mret_in           (mret_in),
    .wfi_in            (wfi_in),
    .valid_in          (valid_in),
    .exception_in      (exception_in),
    .ecause_in         (ecause_in),
    .interrupt_pending (interrupt_pending),
    .rd_write_address  (rd_write_address),
    .rd_write_data     (rd_write_data),
    .csr_write_enable  (csr_write_enable),
    .csr_write_address (csr_write_address),
    .csr_write_data    (csr_write_data),
    .trap              (trap),
    .mret_taken        (mret_taken),
    .trap_cause        (trap_cause),
    .trap_pc           (trap_pc),
    .wfi_stall         (wfi_stall),
    .retired           (retired),
    .instret           (instret)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: cross the active edge and park on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pc_in = 32'h0; next_pc_in = 32'h0; alu_data_in = 32'h0; csr_data_in = 32'h0;
    load_data_in = 32'h0; write_select_in = 2'b00; rd_address_in = 5'd0;
    csr_address_in = 12'h0; csr_write_in = 1'b0; mret_in = 1'b0; wfi_in = 1'b0;
    valid_in = 1'b0; exception_in = 1'b0; ecause_in = 4'd0; interrupt_pending = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    check("reset_wfi_stall", wfi_stall, 0);
    check("reset_instret", instret, 0);
    check("reset_rd_addr", rd_write_address, 0);
    check("reset_retired", retired, 0);
    check("reset_trap", trap, 0);

    // Load result to x5.
    step();
    valid_in = 1; write_select_in = 2'b10; rd_address_in = 5'd5; load_data_in = 32'hDEADBEEF;
    alu_data_in = 32'h11111111;
    #1;
    check("load_rd_addr", rd_write_address, 5);
    check("load_rd_data", rd_write_data, 32'hDEADBEEF);
    check("load_retired", retired, 1);
    check("load_instret_before", instret, 0);
    check("load_csr_we", csr_write_enable, 0);
    step();
    check("load_instret_after", instret, 1);

    // Write to x0 is dropped but still retires.
    write_select_in = 2'b00; rd_address_in = 5'd0; alu_data_in = 32'h00001234;
    #1;
    check("x0_rd_addr", rd_write_address, 0);
    check("x0_rd_data", rd_write_data, 32'h00001234);
    check("x0_retired", retired, 1);
    step();
    check("x0_instret", instret, 2);

    // CSR instruction: CSR read value to rd, ALU value to the CSR.
    write_select_in = 2'b01; rd_address_in = 5'd3; csr_data_in = 32'h0000_0088;
    alu_data_in = 32'h0000_00AA; csr_write_in = 1; csr_address_in = 12'h305;
    #1;
    check("csr_rd_data", rd_write_data, 32'h88);
    check("csr_rd_addr", rd_write_address, 3);
    check("csr_we", csr_write_enable, 1);
    check("csr_waddr", csr_write_address, 12'h305);
    check("csr_wdata", csr_write_data, 32'hAA);
    step();
    check("csr_instret", instret, 3);
    csr_write_in = 0;

    // Link value (next_pc) plus mret.
    write_select_in = 2'b11; next_pc_in = 32'h0000_2004; rd_address_in = 5'd1; mret_in = 1;
    #1;
    check("npc_rd_data", rd_write_data, 32'h2004);
    check("mret_taken", mret_taken, 1);
    step();
    check("mret_instret", instret, 4);

    // Exception beats CSR write, mret and register write.
    exception_in = 1; ecause_in = 4'd4; pc_in = 32'h100; csr_write_in = 1; rd_address_in = 5'd7;
    #1;
    check("exc_trap", trap, 1);
    check("exc_cause", trap_cause, 4);
    check("exc_pc", trap_pc, 32'h100);
    check("exc_csr_we", csr_write_enable, 0);
    check("exc_rd_addr", rd_write_address, 0);
    check("exc_mret", mret_taken, 0);
    check("exc_retired", retired, 0);
    step();
    check("exc_instret", instret, 4);
    check("exc_no_sleep", wfi_stall, 0);
    idle_inputs();

    // WFI with an interrupt already pending retires as a no-op.
    valid_in = 1; wfi_in = 1; interrupt_pending = 1;
    #1;
    check("wfi_pend_retired", retired, 1);
    step();
    check("wfi_pend_stall", wfi_stall, 0);
    check("wfi_pend_instret", instret, 5);
    idle_inputs();
    step();
    check("wfi_pend_stall2", wfi_stall, 0);

    // WFI with nothing pending goes to sleep.
    valid_in = 1; wfi_in = 1;
    #1;
    check("wfi_retired", retired, 1);
    check("wfi_stall_same_cycle", wfi_stall, 0);
    step();
    check("wfi_stall_next", wfi_stall, 1);
    check("wfi_instret", instret, 6);
    wfi_in = 0; write_select_in = 2'b10; rd_address_in = 5'd9; csr_write_in = 1;
    for (int i = 0; i < 10; i++) begin
      exception_in = i[0];
      #1;
      check("sleep_rd_addr", rd_write_address, 0);
      check("sleep_retired", retired, 0);
      check("sleep_trap", trap, 0);
      check("sleep_csr_we", csr_write_enable, 0);
      check("sleep_stall", wfi_stall, 1);
      step();
    end
    exception_in = 0;
    check("sleep_instret", instret, 6);
    interrupt_pending = 1;
    #1;
    check("wake_stall_same", wfi_stall, 1);
    check("wake_retired_same", retired, 0);
    step();
    valid_in = 0;
    #1;
    check("wake_stall_after", wfi_stall, 0);
    check("wake_instret", instret, 6);
    idle_inputs();

    // Counter wrap from all ones.
    step();
    force dut.u_retire_counter.count = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_retire_counter.count;
    #1;
    check("preload_instret", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    valid_in = 1; rd_address_in = 5'd2;
    step();
    check("wrap_instret", instret, 0);

    // Reset while asleep returns to RUN with the counter cleared.
    wfi_in = 1;
    step();
    check("rst_sleep_stall", wfi_stall, 1);
    check("rst_sleep_instret", instret, 1);
    wfi_in = 0; interrupt_pending = 0;
    reset = 1;
    step();
    check("rst_sleep_run", wfi_stall, 0);
    check("rst_sleep_clear", instret, 0);

    // Reset overrides a concurrent commit.
    #1;
    check("rst_commit_retired", retired, 1);
    step();
    check("rst_commit_instret", instret, 0);
    reset = 0;
    step();
    check("post_rst_instret", instret, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
